// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : menu_pkg
// Description : Shared menu-scene definitions. Button geometry is used by both
//               the renderer and the hit test so drawing and clicking agree.
//               Also holds the level-select FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package menu_pkg;

  // Button geometry (screen pixels, unsigned 10-bit)
  localparam logic [9:0] BTN_X0  = 10'd160;  // left edge, inclusive
  localparam logic [9:0] BTN_X1  = 10'd480;  // right edge, exclusive
  localparam logic [9:0] BTN_H   = 10'd60;   // height in rows
  localparam logic [9:0] BTN1_Y0 = 10'd80;
  localparam logic [9:0] BTN2_Y0 = 10'd200;
  localparam logic [9:0] BTN3_Y0 = 10'd320;
  localparam logic [9:0] BTN1_Y1 = BTN1_Y0 + BTN_H;  // exclusive bottoms
  localparam logic [9:0] BTN2_Y1 = BTN2_Y0 + BTN_H;
  localparam logic [9:0] BTN3_Y1 = BTN3_Y0 + BTN_H;

  localparam logic [1:0] LEVEL_NONE = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } sel_state_e;

endpackage : menu_pkg
`default_nettype wire

// File: rtl/menu_hit_test.sv
`default_nettype none
// ============================================================================
// Module      : menu_hit_test
// Description : Combinational map of cursor (x, y) to the LEVEL button under
//               it. Buttons are disjoint so at most one can match.
//               hit_id = 0 for none, 1..3 for a button.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_hit_test
  import menu_pkg::*;
(
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [1:0] hit_id
);

  logic in_col;
  assign in_col = (x >= BTN_X0) && (x < BTN_X1);

  // Priority order is irrelevant: the row bands never overlap
  always_comb begin
    hit_id = LEVEL_NONE;
    if (in_col) begin
      if      ((y >= BTN1_Y0) && (y < BTN1_Y1)) hit_id = 2'd1;
      else if ((y >= BTN2_Y0) && (y < BTN2_Y1)) hit_id = 2'd2;
      else if ((y >= BTN3_Y0) && (y < BTN3_Y1)) hit_id = 2'd3;
    end
  end

endmodule : menu_hit_test
`default_nettype wire

// File: rtl/menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : menu_select_ctrl
// Description : Menu input controller. Produces registered hover flags for
//               the renderer and a one-cycle level-select pulse when a click
//               is pressed and released inside the same LEVEL button.
//               Optional macro MENU_KEY_SEL_EN adds key_valid/key_num for
//               direct keyboard selection from IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_select_ctrl
  import menu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,            // asynchronous, active-low
  input  logic       menu_active,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_left,
`ifdef MENU_KEY_SEL_EN
  input  logic       key_valid,
  input  logic [1:0] key_num,
`endif
  output logic       mouseInLevel1,
  output logic       mouseInLevel2,
  output logic       mouseInLevel3,
  output logic [1:0] level_sel,
  output logic       level_sel_valid
);

  sel_state_e state, state_nxt;
  logic [1:0] armed_id, armed_id_nxt;
  logic [1:0] hit_id;
  logic       prev_left, prev_active;
  logic       press, release_edge, active_rise;
  logic       key_go;
  logic [1:0] key_id;

  menu_hit_test u_hit (
    .x      (mouse_x),
    .y      (mouse_y),
    .hit_id (hit_id)
  );

  assign press        = mouse_left & ~prev_left;
  assign release_edge = ~mouse_left & prev_left;
  assign active_rise  = menu_active & ~prev_active;

`ifdef MENU_KEY_SEL_EN
  assign key_go = key_valid & (key_num != LEVEL_NONE);
  assign key_id = key_num;
`else
  assign key_go = 1'b0;
  assign key_id = LEVEL_NONE;
`endif

  // Edge-detect history and hover flags (hover forced low outside the menu)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_left     <= 1'b0;
      prev_active   <= 1'b0;
      mouseInLevel1 <= 1'b0;
      mouseInLevel2 <= 1'b0;
      mouseInLevel3 <= 1'b0;
    end else begin
      prev_left     <= mouse_left;
      prev_active   <= menu_active;
      mouseInLevel1 <= menu_active && (hit_id == 2'd1);
      mouseInLevel2 <= menu_active && (hit_id == 2'd2);
      mouseInLevel3 <= menu_active && (hit_id == 2'd3);
    end
  end

  // FSM state, armed button and held selection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      armed_id  <= LEVEL_NONE;
      level_sel <= LEVEL_NONE;
    end else begin
      state    <= state_nxt;
      armed_id <= armed_id_nxt;
      // Loading a new selection wins; a fresh menu entry otherwise clears it
      if (state_nxt == FIRE)
        level_sel <= armed_id_nxt;
      else if (active_rise)
        level_sel <= LEVEL_NONE;
    end
  end

  // Next-state decode; the pulse is a decode of FIRE so reset kills it at once
  always_comb begin
    state_nxt       = state;
    armed_id_nxt    = armed_id;
    level_sel_valid = 1'b0;
    case (state)
      IDLE: begin
        if (menu_active && press && (hit_id != LEVEL_NONE)) begin
          state_nxt    = ARMED;
          armed_id_nxt = hit_id;
        end else if (menu_active && key_go) begin
          state_nxt    = FIRE;
          armed_id_nxt = key_id;
        end
      end
      ARMED: begin
        if (!menu_active)
          state_nxt = IDLE;
        else if (release_edge)
          state_nxt = (hit_id == armed_id) ? FIRE : IDLE;
      end
      FIRE: begin
        level_sel_valid = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule : menu_select_ctrl
`default_nettype wire

// File: tb/tb_menu_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_select_ctrl
// Description : Self-checking bench for menu_select_ctrl. Directed scenarios
//               followed by randomized mouse/menu traffic, all compared each
//               cycle against a click-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_select_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       menu_active;
  logic [9:0] mouse_x, mouse_y;
  logic       mouse_left;
  logic       key_valid;
  logic [1:0] key_num;
  logic       mouseInLevel1, mouseInLevel2, mouseInLevel3;
  logic [1:0] level_sel;
  logic       level_sel_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which button a click started on, and a pending pulse
  int m_held, m_sel, m_hover;
  bit m_pending, m_prev_left, m_prev_active;

  always #5 clk = ~clk;

  menu_select_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .menu_active     (menu_active),
    .mouse_x         (mouse_x),
    .mouse_y         (mouse_y),
    .mouse_left      (mouse_left),
`ifdef MENU_KEY_SEL_EN
    .key_valid       (key_valid),
    .key_num         (key_num),
`endif
    .mouseInLevel1   (mouseInLevel1),
    .mouseInLevel2   (mouseInLevel2),
    .mouseInLevel3   (mouseInLevel3),
    .level_sel       (level_sel),
    .level_sel_valid (level_sel_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int button_at(input int x, input int y);
    if (x < 160 || x >= 480) return 0;
    if (y >= 80  && y < 140) return 1;
    if (y >= 200 && y < 260) return 2;
    if (y >= 320 && y < 380) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_held = 0; m_sel = 0; m_hover = 0;
    m_pending = 0; m_prev_left = 0; m_prev_active = 0;
  endtask

  // One clock of the click-level model, using the inputs present at the edge
  task automatic model_step();
    int  h;
    bit  press, rel, loaded, key_ok;
    h      = button_at(int'(mouse_x), int'(mouse_y));
    press  = mouse_left && !m_prev_left;
    rel    = !mouse_left && m_prev_left;
    loaded = 0;
`ifdef MENU_KEY_SEL_EN
    key_ok = key_valid && (key_num != 0);
`else
    key_ok = 0;
`endif
    if (m_pending) begin
      m_pending = 0;
    end else if (m_held == 0) begin
      if (menu_active && press && h != 0) m_held = h;
      else if (menu_active && key_ok) begin
        m_pending = 1; m_sel = int'(key_num); loaded = 1;
      end
    end else begin
      if (!menu_active) m_held = 0;
      else if (rel) begin
        if (h == m_held) begin m_pending = 1; m_sel = m_held; loaded = 1; end
        m_held = 0;
      end
    end
    if (!loaded && menu_active && !m_prev_active) m_sel = 0;
    m_hover       = menu_active ? h : 0;
    m_prev_left   = mouse_left;
    m_prev_active = menu_active;
  endtask

  task automatic compare_all();
    check("hover1",    mouseInLevel1,   m_hover == 1);
    check("hover2",    mouseInLevel2,   m_hover == 2);
    check("hover3",    mouseInLevel3,   m_hover == 3);
    check("level_sel", level_sel,       m_sel);
    check("sel_valid", level_sel_valid, m_pending);
  endtask

  // Called at a negedge: apply inputs, clock once, check at the next negedge
  task automatic cycle(input int x, input int y, input bit left, input bit act);
    mouse_x = 10'(x); mouse_y = 10'(y); mouse_left = left; menu_active = act;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int xs[8] = '{0, 159, 160, 300, 479, 480, 639, 200};
  int ys[14] = '{0, 79, 80, 139, 140, 199, 200, 259, 260, 319, 320, 379, 380, 479};

  initial begin
    int cx, cy;
    bit cl, ca;

    // --- reset held with cursor on button 1 and button down ---
    rst = 1'b0; menu_active = 1'b1; mouse_x = 10'd200; mouse_y = 10'd100;
    mouse_left = 1'b1; key_valid = 1'b0; key_num = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b1;
    cycle(200, 100, 1, 1);
    check("post_reset_hover1", mouseInLevel1, 1'b1);
    check("post_reset_nopulse", level_sel_valid, 1'b0);
    cycle(10, 10, 1, 1);
    cycle(10, 10, 0, 1);

    // --- click in button 2 ---
    cycle(300, 220, 0, 1);
    cycle(300, 220, 1, 1);
    repeat (5) cycle(300, 220, 1, 1);
    cycle(300, 220, 0, 1);
    check("btn2_pulse", level_sel_valid, 1'b1);
    check("btn2_sel", level_sel, 2'd2);
    cycle(300, 220, 0, 1);
    check("btn2_single", level_sel_valid, 1'b0);
    check("btn2_hold", level_sel, 2'd2);

    // --- drag-off cancel ---
    cycle(300, 340, 1, 1);
    cycle(300, 200, 1, 1);
    cycle(300, 100, 1, 1);
    cycle(300, 100, 0, 1);
    check("drag_nopulse", level_sel_valid, 1'b0);
    check("drag_sel_kept", level_sel, 2'd2);
    check("drag_hover1", mouseInLevel1, 1'b1);
    cycle(300, 100, 0, 1);

    // --- corner boundary inside then outside ---
    cycle(479, 139, 1, 1);
    cycle(479, 139, 0, 1);
    check("edge_in_pulse", level_sel_valid, 1'b1);
    check("edge_in_sel", level_sel, 2'd1);
    cycle(480, 139, 0, 1);
    cycle(480, 139, 1, 1);
    cycle(480, 139, 0, 1);
    check("edge_out_nopulse", level_sel_valid, 1'b0);
    check("edge_out_hover", {mouseInLevel1, mouseInLevel2, mouseInLevel3}, 3'b000);
    cycle(479, 140, 0, 1);
    check("y140_out", mouseInLevel1, 1'b0);

    // --- menu drops while armed on button 3 ---
    cycle(400, 350, 1, 1);
    cycle(400, 350, 1, 0);
    check("drop_hover3", mouseInLevel3, 1'b0);
    cycle(400, 350, 1, 1);
    check("reenter_clear", level_sel, 2'd0);
    cycle(400, 350, 0, 1);
    check("drop_nopulse", level_sel_valid, 1'b0);
    cycle(400, 350, 0, 1);

    // --- async reset while armed aborts the click ---
    cycle(300, 230, 1, 1);
    rst = 1'b0; mouse_left = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    cycle(300, 230, 0, 1);
    check("abort_nopulse", level_sel_valid, 1'b0);

`ifdef MENU_KEY_SEL_EN
    key_valid = 1'b1; key_num = 2'd3;
    cycle(10, 10, 0, 1);
    check("key3_pulse", level_sel_valid, 1'b1);
    check("key3_sel", level_sel, 2'd3);
    key_num = 2'd0;
    cycle(10, 10, 0, 1);
    cycle(10, 10, 0, 1);
    check("key0_nopulse", level_sel_valid, 1'b0);
    key_valid = 1'b0;
`endif

    // --- randomized traffic ---
    cx = 300; cy = 220; cl = 0; ca = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2, 0) == 0) begin
        cx = ($urandom_range(3, 0) == 0) ? int'($urandom_range(639, 0)) : xs[$urandom_range(7, 0)];
        cy = ($urandom_range(3, 0) == 0) ? int'($urandom_range(479, 0)) : ys[$urandom_range(13, 0)];
      end
      if ($urandom_range(3, 0) == 0) cl = !cl;
      if (ca && $urandom_range(39, 0) == 0) ca = 0;
      else if (!ca && $urandom_range(4, 0) == 0) ca = 1;
`ifdef MENU_KEY_SEL_EN
      key_valid = ($urandom_range(7, 0) == 0);
      key_num   = 2'($urandom_range(3, 0));
`endif
      cycle(cx, cy, cl, ca);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_menu_select_ctrl
`default_nettype wire
